// File: rtl/slice_serial_add_sub.sv
// ---------------------------------------------------------------------------
// slice_serial_add_sub
//
// Multicycle adder/subtractor. Computes data0 +/- data1 over WIDTH bits,
// SLICE bits per clock, through a single (SLICE+1)-bit adder. The carry
// between slices is held in a register. Reports carry, signed overflow and
// zero alongside the result.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and its payload until it is taken,
// and the consumer may hold ready low for as long as it likes. in_ready is
// high only in IDLE. out_valid is high only in DONE, and the result fields
// stay stable until the output transfer.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands and mode valid
//   in_ready   out  1      block can accept a new operation
//   data0      in   WIDTH  operand A
//   data1      in   WIDTH  operand B
//   mode       in   1      1 = A+B, 0 = A-B
//   out_valid  out  1      result fields valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result modulo 2^WIDTH
//   carry_out  out  1      MSB carry; for subtract 1 = no borrow
//   overflow   out  1      two's-complement signed overflow
//   zero       out  1      sum == 0 (only while out_valid)
// ---------------------------------------------------------------------------
module slice_serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;      // already complemented for subtract
    logic             carry_reg;
    logic             zero_acc;   // every slice produced so far was zero
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE:0]   slice_res;

    assign in_ready = (state == IDLE);

    // Select the operand slice addressed by cnt. The loop builds a plain mux
    // with constant part-selects.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt == CW'(i)) begin
                a_slice = a_reg[i*SLICE +: SLICE];
                b_slice = b_reg[i*SLICE +: SLICE];
            end
        end
    end

    // The only adder in the block: SLICE+1 bits wide, with the carry-in
    // taken from the carry register.
    assign slice_res = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            zero_acc  <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1. The +1 enters as the
                        // initial carry.
                        a_reg     <= data0;
                        b_reg     <= data1 ^ {WIDTH{~mode}};
                        carry_reg <= ~mode;
                        zero_acc  <= 1'b1;
                        cnt       <= '0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (cnt == CW'(i)) begin
                            sum[i*SLICE +: SLICE] <= slice_res[SLICE-1:0];
                        end
                    end
                    carry_reg <= slice_res[SLICE];
                    zero_acc  <= zero_acc && (slice_res[SLICE-1:0] == '0);
                    if (cnt == LAST_CNT) begin
                        // On the top slice, slice_res[SLICE-1] is the final
                        // sum MSB.
                        carry_out <= slice_res[SLICE];
                        overflow  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                     (slice_res[SLICE-1] != a_reg[WIDTH-1]);
                        zero      <= zero_acc && (slice_res[SLICE-1:0] == '0);
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        // sum/carry_out/overflow keep their values. zero is
                        // cleared so that it is never high without
                        // out_valid.
                        out_valid <= 1'b0;
                        zero      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slice_serial_add_sub.sv
module tb_slice_serial_add_sub;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int N_RAND = 3000;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    int tests = 0;
    int fails = 0;

    // {sum, carry, overflow, zero}
    logic [WIDTH+2:0] exp_q[$];

    slice_serial_add_sub #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data0     (data0),
        .data1     (data1),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Works on integers: unsigned and signed results are computed separately
    // and then range-checked.
    function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic m);
        longint ua, ub, sa, sb, ur, sr, smax, smin;
        logic [WIDTH-1:0] s;
        logic c, ov;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) << (WIDTH - 1)) - 1;
        smin = -smax - 1;
        if (m) begin
            ur = ua + ub;
            sr = sa + sb;
            c  = (ur >= (longint'(1) << WIDTH));
        end else begin
            ur = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end
        s  = ur[WIDTH-1:0];
        ov = (sr > smax) || (sr < smin);
        return {s, c, ov, (s == '0)};
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag, input logic [WIDTH+2:0] e);
        chk({tag, ".valid"}, 64'(out_valid), 64'(1));
        chk({tag, ".sum"},   64'(sum),       64'(e[WIDTH+2:3]));
        chk({tag, ".carry"}, 64'(carry_out), 64'(e[2]));
        chk({tag, ".ovf"},   64'(overflow),  64'(e[1]));
        chk({tag, ".zero"},  64'(zero),      64'(e[0]));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".in_ready"},  64'(in_ready),  64'(1));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, ".sum"},       64'(sum),       64'(0));
        chk({tag, ".carry"},     64'(carry_out), 64'(0));
        chk({tag, ".ovf"},       64'(overflow),  64'(0));
        chk({tag, ".zero"},      64'(zero),      64'(0));
    endtask

    // ---------------- driver tasks ----------------
    // Presents one operation and returns on the falling edge right after the
    // accepting rising edge.
    task automatic send(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic m);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk({tag, ".accept_timeout"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        data0    = a;
        data1    = b;
        mode     = m;
        @(negedge clk);
        // Scramble the inputs: they must not matter after the accept.
        in_valid = 1'b0;
        data0    = WIDTH'($urandom);
        data1    = WIDTH'($urandom);
        mode     = 1'($urandom);
    endtask

    // Counts the rising edges from the accept until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic m);
        int lat;
        send(tag, a, b, m);
        wait_result(lat);
        chk({tag, ".latency"}, 64'(lat), 64'(NSLICE));
        chk_result(tag, model(a, b, m));
        @(negedge clk);
        chk({tag, ".drop_valid"}, 64'(out_valid), 64'(0));
        chk({tag, ".ready_again"}, 64'(in_ready), 64'(1));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [WIDTH+2:0] e;
        logic [WIDTH-1:0] ra, rb;
        logic             rm;
        int lat, sent, got, cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data0     = '0;
        data1     = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // arithmetic corners
        do_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b1);
        do_op("sub_5_5",    16'h0005, 16'h0005, 1'b0);
        do_op("sub_0_1",    16'h0000, 16'h0001, 1'b0);
        do_op("sub_8000_1", 16'h8000, 16'h0001, 1'b0);
        do_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b1);

        // backpressure with a second request waiting
        out_ready = 1'b0;
        send("bp_op1", 16'h1234, 16'h0F0F, 1'b1);
        wait_result(lat);
        chk("bp.latency", 64'(lat), 64'(NSLICE));
        e = model(16'h1234, 16'h0F0F, 1'b1);
        in_valid = 1'b1;
        data0    = 16'hA5A5;
        data1    = 16'h5A5A;
        mode     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_result("bp.hold", e);
            chk("bp.in_ready_low", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.released_valid", 64'(out_valid), 64'(0));
        chk("bp.released_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        chk("bp.op2_taken", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        wait_result(lat);
        chk("bp.op2_latency", 64'(lat), 64'(NSLICE));
        chk_result("bp.op2", model(16'hA5A5, 16'h5A5A, 1'b0));
        @(negedge clk);

        // asynchronous reset two cycles into CALC
        send("rst_op", 16'h1234, 16'h1111, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        @(negedge clk);
        chk_all_zero("mid_reset_held");
        rst_n = 1'b1;
        do_op("after_reset", 16'h8001, 16'h7FFF, 1'b0);

        // random sweep with random out_ready
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < N_RAND && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rand.unexpected_result", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk_result("rand", e);
                        got++;
                    end
                end
            end else begin
                chk("rand.zero_idle", 64'(zero), 64'(0));
            end
            if (in_ready && sent < N_RAND && $urandom_range(0, 1) == 1) begin
                ra = WIDTH'($urandom);
                rb = WIDTH'($urandom);
                rm = 1'($urandom);
                // bias some operands toward the corners
                if ($urandom_range(0, 7) == 0) rb = ra;
                if ($urandom_range(0, 7) == 0) ra = {1'b0, {(WIDTH-1){1'b1}}};
                in_valid = 1'b1;
                data0    = ra;
                data1    = rb;
                mode     = rm;
                exp_q.push_back(model(ra, rb, rm));
                sent++;
            end else begin
                // noise on in_valid only while busy, where it must be ignored
                in_valid = in_ready ? 1'b0 : 1'($urandom);
                data0    = WIDTH'($urandom);
                data1    = WIDTH'($urandom);
                mode     = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        chk("rand.all_sent", 64'(sent), 64'(N_RAND));
        chk("rand.one_result_each", 64'(got), 64'(sent));
        chk("rand.queue_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
